// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial sequence detector.
//
// Detects a pattern of 1..MAX_LEN bits on a qualified serial input, in overlapping or
// non-overlapping mode. The first-received bit of a pattern is pattern[len-1] and the
// last one is pattern[0].
//
// Optional feature (macro SEQ_DET_CNT_EN):
//   defined   - match_cnt is a saturating match counter, cleared by cnt_clr.
//   undefined - no counter register; match_cnt is tied to 0 and cnt_clr is ignored.
//
// Ports:
//   clk, rst      clock (posedge) and asynchronous active-high reset
//   X, X_valid    serial data bit and its qualifier
//   cfg_load      load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern   right-justified pattern
//   cfg_len       pattern length; 0 or > MAX_LEN is rejected
//   cfg_overlap   1 = overlapping detection, 0 = non-overlapping
//   Y             registered one-cycle match pulse
//   cfg_err       registered one-cycle pulse on a rejected load
//   match_cnt     saturating match count
//   cnt_clr       synchronous clear of match_cnt (wins over a same-cycle match)
module seq_detect_param #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b10110),
  parameter int unsigned DEF_LEN     = 5,
  parameter bit          DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               X,
  input  logic               X_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               Y,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               y_q, err_q;

  logic               cfg_ok, cfg_bad, armed, match;
  logic [LEN_W:0]     fill_p1;
  logic [MAX_LEN-1:0] window, mask;

  assign cfg_ok  = cfg_load && (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W + 1)'(MAX_LEN));
  assign cfg_bad = cfg_load && !cfg_ok;

  // ARMED when fill >= len-1; widened by one bit so fill+1 cannot wrap.
  assign fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
  assign armed   = fill_p1 >= {1'b0, len_q};

  // Newest len bits, X included; the MSB of hist never reaches the comparison.
  assign window = {hist_q[MAX_LEN-2:0], X};
  assign mask   = ~({MAX_LEN{1'b1}} << len_q);
  assign match  = X_valid && !cfg_ok && armed && (((window ^ pat_q) & mask) == '0);

  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[MAX_LEN-1];

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (cfg_ok) begin
      // A good load discards the same-cycle bit and restarts detection.
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (X_valid) begin
      if (match && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window;
        if (fill_q < len_q) fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      y_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      y_q    <= match;
      err_q  <= cfg_bad;
    end
  end

  assign Y       = y_q;
  assign cfg_err = err_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                    cnt_d = '0;
    else if (match && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = 4;
  localparam int unsigned CntW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            X, X_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [MaxLen-1:0] cfg_pattern;
  logic [LenW-1:0] cfg_len;
  logic            Y, cfg_err;
  logic [CntW-1:0] match_cnt;

  seq_detect_param #(
    .MAX_LEN (MaxLen),
    .LEN_W   (LenW),
    .CNT_W   (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .X           (X),
    .X_valid     (X_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .Y           (Y),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt),
    .cnt_clr     (cnt_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the bits received since the last clear, oldest first.
  typedef struct packed {logic y; logic err; logic [CntW-1:0] cnt;} exp_t;
  exp_t          exp_q[$];
  bit            bits_q[$];
  logic [MaxLen-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  int            m_cnt;
  int            y_seen, err_seen;

  task automatic model_reset();
    bits_q.delete();
    m_pat = MaxLen'('b10110);
    m_len = 5;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  // Drive one cycle, push the model's expectation, then pop/compare after the edge.
  task automatic step(input bit x, input bit v, input bit ld, input logic [MaxLen-1:0] pat,
                      input int len, input bit ovl, input bit clr);
    bit   ok, bad, m, b;
    exp_t e, got;
    X = x; X_valid = v; cfg_load = ld; cfg_pattern = pat;
    cfg_len = LenW'(len); cfg_overlap = ovl; cnt_clr = clr;
    ok  = ld && len >= 1 && len <= MaxLen;
    bad = ld && !ok;
    m   = 1'b0;
    if (v && !ok && (bits_q.size() + 1 >= m_len)) begin
      m = 1'b1;
      for (int i = 0; i < m_len; i++) begin
        b = (i == 0) ? x : bits_q[bits_q.size() - i];
        if (b != m_pat[i]) m = 1'b0;
      end
    end
    if (ok) begin
      m_pat = pat; m_len = len; m_ovl = ovl; bits_q.delete();
    end else if (v) begin
      if (m && !m_ovl) bits_q.delete();
      else begin
        bits_q.push_back(x);
        if (bits_q.size() > MaxLen) void'(bits_q.pop_front());
      end
    end
`ifdef SEQ_DET_CNT_EN
    if (clr) m_cnt = 0;
    else if (m && m_cnt < (1 << CntW) - 1) m_cnt++;
`else
    m_cnt = 0;
`endif
    e.y = m; e.err = bad; e.cnt = CntW'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq("Y", int'(Y), int'(got.y));
    check_eq("cfg_err", int'(cfg_err), int'(got.err));
    check_eq("match_cnt", int'(match_cnt), int'(got.cnt));
    if (Y) y_seen++;
    if (cfg_err) err_seen++;
  endtask

  task automatic bit_in(input bit x);
    step(x, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [MaxLen-1:0] pat, input int len, input bit ovl);
    step(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
  endtask

  task automatic send(input logic [MaxLen-1:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_eq("rst_Y", int'(Y), 0);
    check_eq("rst_cnt", int'(match_cnt), 0);
    check_eq("rst_err", int'(cfg_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int cnt_max;

  initial begin
`ifdef SEQ_DET_CNT_EN
    cnt_max = 3;
`else
    cnt_max = 0;
`endif
    X = 0; X_valid = 0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; cnt_clr = 0; rst = 0;
    #3;
    do_reset();

    // Defaults, overlapping: pulses after bits 5 and 8.
    y_seen = 0;
    send(8'b1011_0110, 8);
    check_eq("def_ovl_pulses", y_seen, 2);
    check_eq("def_ovl_cnt", int'(match_cnt), cnt_max >= 2 ? 2 : 0);

    // Non-overlapping 10110: only after bit 5.
    load(8'b1_0110, 5, 1'b0);
    y_seen = 0;
    send(8'b1011_0110, 8);
    check_eq("novl_pulses", y_seen, 1);

    // 111 overlapping / non-overlapping on five ones.
    load(8'b111, 3, 1'b1);
    y_seen = 0;
    send(8'b1_1111, 5);
    check_eq("ones_ovl_pulses", y_seen, 3);
    check_eq("cnt_saturated", int'(match_cnt), cnt_max);
    load(8'b111, 3, 1'b0);
    y_seen = 0;
    send(8'b1_1111, 5);
    check_eq("ones_novl_pulses", y_seen, 1);

    // 10110 with X_valid gaps of 1..3 cycles.
    load(8'b1_0110, 5, 1'b1);
    y_seen = 0;
    for (int i = 4; i >= 0; i--) begin
      bit_in(((5'b10110) >> i) & 1'b1);
      if (i != 0) idle(1 + (i % 3));
    end
    check_eq("gap_pulses", y_seen, 1);

    // Reset after three bits of a second 10110 loses the partial match.
    y_seen = 0;
    send(8'b101, 3);
    do_reset();
    send(8'b10, 2);
    check_eq("rst_mid_pulses", y_seen, 0);

    // Rejected loads during a partial match; old pattern still completes.
    y_seen = 0; err_seen = 0;
    send(8'b101, 3);
    step(1'b1, 1'b1, 1'b1, 8'h0F, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h0F, MaxLen + 1, 1'b0, 1'b0);
    bit_in(1'b0);
    check_eq("bad_load_errs", err_seen, 2);
    check_eq("bad_load_pulses", y_seen, 1);

    // cnt_clr wins over a same-cycle match.
    send(8'b1011, 4);
    step(1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
    check_eq("clr_vs_match_cnt", int'(match_cnt), 0);
    check_eq("clr_vs_match_Y", int'(Y), 1);

    // len=1: back-to-back pulses on consecutive valid ones.
    load(8'b1, 1, 1'b1);
    y_seen = 0;
    send(8'b1101, 4);
    check_eq("len1_pulses", y_seen, 3);

    // Random stream with occasional (sometimes illegal) reconfiguration.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'($urandom), 1'($urandom), 1'b1, MaxLen'($urandom), $urandom_range(0, 9),
             1'($urandom), 1'b0);
      else
        step(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, '0, 0, 1'b0,
             ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
